wb_fifo_slave: RTL and testbench

//  Wishbone B3 slave responder: the target end of the daq/dsp master bus interface.
//  - DATA register is backed by a sample FIFO: master writes push, master reads pop.
//  - Also provides STATUS and CTRL registers.
//  - Sits on the bus matrix beside the wb_ram slaves; gives masters a flow-controlled queue.

---
 rtl/wb_fifo_slave_if.sv | 30 +++
 rtl/wb_fifo_slave.sv | 221 ++++++++++++++++++++++
 tb/tb_wb_fifo_slave.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_fifo_slave_if.sv
// Wishbone B3 slave-side bus bundle for wb_fifo_slave.
// Carries the request signals from the master and the termination and read
// data back. Clock and reset stay as plain ports on the slave.
interface wb_fifo_slave_if #(
  parameter int dw = 32,
  parameter int aw = 32
);
  logic [aw-1:0] adr_i;
  logic [dw-1:0] dat_i;
  logic [3:0]    sel_i;
  logic          we_i;
  logic          cyc_i;
  logic          stb_i;
  logic [2:0]    cti_i;
  logic [1:0]    bte_i;
  logic [dw-1:0] dat_o;
  logic          ack_o;
  logic          err_o;
  logic          rty_o;

  modport slave (
    input  adr_i, dat_i, sel_i, we_i, cyc_i, stb_i, cti_i, bte_i,
    output dat_o, ack_o, err_o, rty_o
  );

  modport master (
    output adr_i, dat_i, sel_i, we_i, cyc_i, stb_i, cti_i, bte_i,
    input  dat_o, ack_o, err_o, rty_o
  );
endinterface

// File: rtl/wb_fifo_slave.sv
// Wishbone B3 slave exposing a sample FIFO behind a DATA register, plus
// STATUS and CTRL registers. Writes to DATA push, reads pop. Incrementing
// bursts (cti=010) on DATA are acked every cycle while stb is held.
// Optional feature macro: WB_FIFO_SLAVE_IRQ_EN enables the threshold /
// sticky-flag level interrupt and the CTRL irq_en/thresh fields.
module wb_fifo_slave #(
  parameter int dw    = 32,
  parameter int aw    = 32,
  parameter int DEPTH = 16,
  parameter int AW_F  = 4
) (
  input  logic           wb_clk,
  input  logic           wb_rst,
  wb_fifo_slave_if.slave wb_s,
  output logic [AW_F:0]  fifo_count,
  output logic           irq
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESP  = 2'd1,
    BURST = 2'd2
  } state_t;

  localparam logic [2:0]      CTI_INCR = 3'b010;
  localparam logic [AW_F:0]   FULL_CNT = (AW_F + 1)'(DEPTH);
  localparam logic [AW_F:0]   CNT_ONE  = 1;
  localparam logic [AW_F-1:0] PTR_ONE  = 1;

  state_t          state_q, state_d;
  logic [AW_F-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW_F-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW_F:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic [dw-1:0]   mem [DEPTH];

  logic            fifo_empty, fifo_full, active;
  logic [1:0]      reg_sel;
  logic            ack, err, rty;
  logic            push, pop, flush;
  logic            set_ovf, set_unf, clr_ovf, clr_unf, ctrl_we;
  logic [dw-1:0]   status_word, ctrl_word, rdata;
  logic            unused_bus;

  assign reg_sel     = wb_s.adr_i[3:2];
  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == FULL_CNT);
  assign status_word = {12'd0, unf_q, ovf_q, fifo_full, fifo_empty, 16'(count_q)};
  assign unused_bus  = ^{wb_s.adr_i[aw-1:4], wb_s.adr_i[1:0], wb_s.bte_i};

  // Bus FSM and register decode: terminations are driven only in RESP/BURST,
  // and every side-effect strobe is qualified by the termination it rides on.
  always_comb begin
    state_d = state_q;
    active  = 1'b0;
    ack     = 1'b0;
    err     = 1'b0;
    rty     = 1'b0;
    rdata   = '0;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    clr_ovf = 1'b0;
    clr_unf = 1'b0;
    ctrl_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (wb_s.cyc_i && wb_s.stb_i) state_d = RESP;
      end
      RESP, BURST: begin
        // Any non-continuing outcome (classic beat, cti=111, error, retry,
        // stb or cyc dropped) returns to IDLE.
        state_d = IDLE;
        active  = wb_s.cyc_i && wb_s.stb_i;
      end
      default: state_d = IDLE;
    endcase

    if (active) begin
      case (reg_sel)
        2'd0: begin
          if (wb_s.we_i) begin
            if (wb_s.sel_i != 4'hF) begin
              err = 1'b1;
            end else if (fifo_full) begin
              rty     = 1'b1;
              set_ovf = 1'b1;
            end else begin
              ack  = 1'b1;
              push = 1'b1;
            end
          end else begin
            ack = 1'b1;
            if (fifo_empty) begin
              set_unf = 1'b1;
            end else begin
              pop   = 1'b1;
              rdata = mem[rd_ptr_q];
            end
          end
        end
        2'd1: begin
          ack = 1'b1;
          if (wb_s.we_i) begin
            clr_ovf = wb_s.dat_i[18];
            clr_unf = wb_s.dat_i[19];
          end else begin
            rdata = status_word;
          end
        end
        2'd2: begin
          ack = 1'b1;
          if (wb_s.we_i) begin
            ctrl_we = 1'b1;
            flush   = wb_s.dat_i[0];
          end else begin
            rdata = ctrl_word;
          end
        end
        default: err = 1'b1;
      endcase
      if (ack && (reg_sel == 2'd0) && (wb_s.cti_i == CTI_INCR)) state_d = BURST;
    end
  end

  assign wb_s.ack_o = ack;
  assign wb_s.err_o = err;
  assign wb_s.rty_o = rty;
  assign wb_s.dat_o = rdata;
  assign fifo_count = count_q;

  // FIFO pointer/occupancy and sticky-flag next state; flush overrides push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        count_d  = count_q + CNT_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        count_d  = count_q - CNT_ONE;
      end
    end
    ovf_d = set_ovf | (ovf_q & ~clr_ovf);
    unf_d = set_unf | (unf_q & ~clr_unf);
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Sample storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge wb_clk) begin
    if (push) mem[wr_ptr_q] <= wb_s.dat_i;
  end

`ifdef WB_FIFO_SLAVE_IRQ_EN
  logic        irq_en_q, irq_en_d;
  logic [15:0] thresh_q, thresh_d;
  logic        irq_q, irq_d;

  assign ctrl_word = {thresh_q, 14'd0, irq_en_q, 1'b0};
  assign irq       = irq_q;

  // CTRL field update and registered interrupt condition.
  always_comb begin
    irq_en_d = irq_en_q;
    thresh_d = thresh_q;
    if (ctrl_we) begin
      irq_en_d = wb_s.dat_i[1];
      thresh_d = wb_s.dat_i[31:16];
    end
    irq_d = irq_en_q & ((16'(count_q) >= thresh_q) | ovf_q | unf_q);
  end

  // Interrupt and CTRL registers with asynchronous clear.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      irq_en_q <= 1'b0;
      thresh_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      thresh_q <= thresh_d;
      irq_q    <= irq_d;
    end
  end
`else
  logic unused_ctrl;

  assign ctrl_word   = '0;
  assign irq         = 1'b0;
  assign unused_ctrl = ctrl_we;
`endif

endmodule

// File: tb/tb_wb_fifo_slave.sv
// Bench for wb_fifo_slave: a queue-based model predicts each bus beat's
// termination and read data; a negedge monitor compares them against the bus.
module tb_wb_fifo_slave;
  localparam int DEPTH = 16;
  localparam int AW_F  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW_F:0] fifo_count;
  logic          irq;

  wb_fifo_slave_if #(.dw(32), .aw(32)) bus ();

  wb_fifo_slave #(.dw(32), .aw(32), .DEPTH(DEPTH), .AW_F(AW_F)) dut (
    .wb_clk     (clk),
    .wb_rst     (rst),
    .wb_s       (bus),
    .fifo_count (fifo_count),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          term;   // 0 ack, 1 err, 2 rty
    bit          chk;
    logic [31:0] dat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mq[$];
  bit          m_ovf, m_unf, m_irq_en;
  logic [15:0] m_thresh;
  logic [31:0] wbuf [0:31];
  int          n_chk = 0;
  int          n_pass = 0;
  int          ack_cnt = 0;
  exp_t        mon_e;
  int          mon_term;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    m_irq_en = 1'b0;
    m_thresh = '0;
  endfunction

  // Register-level behaviour of one bus beat.
  function automatic void model_access(input bit we, input logic [1:0] r, input logic [31:0] d,
                                       input logic [3:0] sel, output int term, output logic [31:0] rd);
    term = 0;
    rd   = '0;
    case (r)
      2'd0: begin
        if (we) begin
          if (sel != 4'hF) term = 1;
          else if (mq.size() == DEPTH) begin term = 2; m_ovf = 1'b1; end
          else mq.push_back(d);
        end else begin
          if (mq.size() == 0) m_unf = 1'b1;
          else rd = mq.pop_front();
        end
      end
      2'd1: begin
        if (we) begin
          if (d[18]) m_ovf = 1'b0;
          if (d[19]) m_unf = 1'b0;
        end else begin
          rd = {12'd0, m_unf, m_ovf, 1'(mq.size() == DEPTH), 1'(mq.size() == 0), 16'(mq.size())};
        end
      end
      2'd2: begin
        if (we) begin
`ifdef WB_FIFO_SLAVE_IRQ_EN
          m_irq_en = d[1];
          m_thresh = d[31:16];
`endif
          if (d[0]) mq.delete();
        end else begin
`ifdef WB_FIFO_SLAVE_IRQ_EN
          rd = {m_thresh, 14'd0, m_irq_en, 1'b0};
`else
          rd = '0;
`endif
        end
      end
      default: term = 1;
    endcase
  endfunction

  // Monitor: every termination consumes one expected beat; otherwise dat_o must be 0.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ack_o || bus.err_o || bus.rty_o) begin
        if (bus.ack_o) ack_cnt++;
        check("term_onehot", 32'(bus.ack_o) + 32'(bus.err_o) + 32'(bus.rty_o), 32'd1);
        check("exp_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e    = exp_q.pop_front();
          mon_term = bus.ack_o ? 0 : (bus.err_o ? 1 : 2);
          check("term_kind", mon_term, mon_e.term);
          if (mon_e.chk) check("rd_data", bus.dat_o, mon_e.dat);
        end
      end else begin
        check("dat_idle_zero", bus.dat_o, 32'd0);
      end
    end
  end

  task automatic xfer(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                      input int n, output int lat);
    int          term;
    logic [31:0] rd;
    int          w;
    bit          got;
    exp_t        e;
    lat = 0;
    @(posedge clk); #1;
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = we;
    bus.adr_i = adr;
    bus.sel_i = sel;
    for (int b = 0; b < n; b++) begin
      bus.cti_i = (n == 1) ? 3'b000 : ((b == n - 1) ? 3'b111 : 3'b010);
      bus.dat_i = we ? wbuf[b] : $urandom;
      model_access(we, adr[3:2], wbuf[b], sel, term, rd);
      e.term = term;
      e.chk  = !we;
      e.dat  = rd;
      exp_q.push_back(e);
      w   = 0;
      got = 1'b0;
      while (!got && w < 20) begin
        @(negedge clk);
        w++;
        got = bus.ack_o || bus.err_o || bus.rty_o;
      end
      check("term_seen", 32'(got), 32'd1);
      if (b == 0) lat = w;
      @(posedge clk); #1;
      if (!got) begin
        exp_q.delete();
        break;
      end
      if (term != 0) break;
    end
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
    bus.cti_i = 3'b000;
  endtask

  task automatic wr1(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] sel);
    int l;
    wbuf[0] = d;
    xfer(1'b1, adr, sel, 1, l);
  endtask

  task automatic rd1(input logic [31:0] adr);
    int l;
    xfer(1'b0, adr, 4'hF, 1, l);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, a0, op, len;
    logic [31:0] d, radr;
    bit          rwe;
    int          term;
    logic [31:0] rd;
    exp_t        e;

    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
    bus.adr_i = '0;
    bus.dat_i = '0;
    bus.sel_i = 4'hF;
    bus.cti_i = 3'b000;
    bus.bte_i = 2'b00;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(bus.ack_o), 32'd0);
    check("rst_err", 32'(bus.err_o), 32'd0);
    check("rst_rty", 32'(bus.rty_o), 32'd0);
    check("rst_dat", bus.dat_o, 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    #2 rst = 1'b0;

    // Classic write then STATUS read
    wbuf[0] = 32'hA5A5_0001;
    xfer(1'b1, 32'h0, 4'hF, 1, lat);
    check("classic_latency", lat, 32'd2);
    check("count_after_write", 32'(fifo_count), 32'd1);
    rd1(32'h4);
    rd1(32'h0);

    // Fill with a 16-beat burst, then overflow
    for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
    a0 = ack_cnt;
    xfer(1'b1, 32'h0, 4'hF, 16, lat);
    check("burst_acks", ack_cnt - a0, 32'd16);
    check("count_full", 32'(fifo_count), 32'd16);
    rd1(32'h4);
    wr1(32'h0, 32'hDEAD_BEEF, 4'hF);
    check("count_after_rty", 32'(fifo_count), 32'd16);
    rd1(32'h4);

    // Drain by burst, underflow, clear sticky flags
    xfer(1'b0, 32'h0, 4'hF, 16, lat);
    check("count_drained", 32'(fifo_count), 32'd0);
    rd1(32'h0);
    rd1(32'h4);
    wr1(32'h4, 32'h000C_0000, 4'hF);
    rd1(32'h4);

    // Partial select and reserved address
    wr1(32'h0, 32'h1234_5678, 4'h3);
    check("count_after_sel_err", 32'(fifo_count), 32'd0);
    rd1(32'hC);
    wr1(32'hC, 32'h0, 4'hF);

    // Flush
    for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
    xfer(1'b1, 32'h0, 4'hF, 3, lat);
    check("count_before_flush", 32'(fifo_count), 32'd3);
    wr1(32'h8, 32'h1, 4'hF);
    check("count_after_flush", 32'(fifo_count), 32'd0);
    rd1(32'h8);

`ifdef WB_FIFO_SLAVE_IRQ_EN
    wr1(32'h8, 32'h0004_0002, 4'hF);
    for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
    xfer(1'b1, 32'h0, 4'hF, 3, lat);
    repeat (3) @(negedge clk);
    check("irq_below_thresh", 32'(irq), 32'd0);
    wr1(32'h0, $urandom, 4'hF);
    repeat (2) @(negedge clk);
    check("irq_at_thresh", 32'(irq), 32'd1);
    rd1(32'h0);
    repeat (2) @(negedge clk);
    check("irq_after_pop", 32'(irq), 32'd0);
    rd1(32'h8);
    wr1(32'h8, 32'h1, 4'hF);
`endif

    // Randomized traffic
    for (int t = 0; t < 250; t++) begin
      op   = $urandom_range(0, 9);
      radr = $urandom & 32'hFFFF_FFF3;
      case (op)
        0, 1: wr1(radr, $urandom, ($urandom_range(0, 7) == 0) ? 4'h3 : 4'hF);
        2: rd1(radr);
        3: begin
          len = $urandom_range(2, 8);
          for (int i = 0; i < len; i++) wbuf[i] = $urandom;
          xfer(1'b1, radr, 4'hF, len, lat);
        end
        4: begin
          len = $urandom_range(2, 8);
          xfer(1'b0, radr, 4'hF, len, lat);
        end
        5: rd1(radr | 32'h4);
        6: wr1(radr | 32'h4, $urandom, 4'hF);
        7: begin
          d    = $urandom;
          d[0] = ($urandom_range(0, 3) == 0);
          wr1(radr | 32'h8, d, 4'hF);
        end
        8: rd1(radr | 32'h8);
        default: begin
          rwe = 1'($urandom_range(0, 1));
          if (rwe) wr1(radr | 32'hC, $urandom, 4'hF);
          else rd1(radr | 32'hC);
        end
      endcase
      check("count_track", 32'(fifo_count), 32'(mq.size()));
    end
`ifndef WB_FIFO_SLAVE_IRQ_EN
    check("irq_tied_low", 32'(irq), 32'd0);
`endif

    // Reset in the middle of a burst
    wr1(32'h8, 32'h1, 4'hF);
    @(posedge clk); #1;
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = 1'b1;
    bus.adr_i = 32'h0;
    bus.sel_i = 4'hF;
    bus.cti_i = 3'b010;
    for (int b = 0; b < 2; b++) begin
      bus.dat_i = $urandom;
      model_access(1'b1, 2'd0, bus.dat_i, 4'hF, term, rd);
      e.term = term;
      e.chk  = 1'b0;
      e.dat  = rd;
      exp_q.push_back(e);
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!bus.ack_o && lat < 20);
      check("burst_beat_ack", 32'(bus.ack_o), 32'd1);
      if (b == 0) begin
        @(posedge clk); #1;
      end
    end
    #2 rst = 1'b1;
    #1;
    check("midrst_ack", 32'(bus.ack_o), 32'd0);
    check("midrst_count", 32'(fifo_count), 32'd0);
    check("midrst_dat", bus.dat_o, 32'd0);
    model_reset();
    exp_q.delete();
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.cti_i = 3'b000;
    @(negedge clk);
    #2 rst = 1'b0;
    xfer(1'b0, 32'h4, 4'hF, 1, lat);
    check("post_rst_latency", lat, 32'd2);
    rd1(32'h8);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
